// File: rtl/nn_pkg.sv
// Shared types and defaults for the neural-net output stages.
`timescale 1ns/1ps
package nn_pkg;

    localparam int N_CLASSES = 10;
    localparam int SCORE_W   = 64;
    localparam int IDX_W     = 4;

    typedef logic [SCORE_W-1:0] score_t;
    typedef logic [IDX_W-1:0]   class_idx_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } argmax_state_e;

endpackage

// File: rtl/score_compare.sv
// Combinational strict greater-than between two scores, signed or unsigned.
`timescale 1ns/1ps
module score_compare #(
    parameter int W          = 64,
    parameter int SIGNED_CMP = 1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         gt
);

    generate
        if (SIGNED_CMP != 0) begin : g_signed
            assign gt = $signed(a) > $signed(b);
        end else begin : g_unsigned
            assign gt = a > b;
        end
    endgenerate

endmodule

// File: rtl/argmax_scorer.sv
// Sequential arg-max over one score vector per transaction, with running
// correct/total statistics against a supplied label.
`timescale 1ns/1ps
module argmax_scorer #(
    parameter int N_CLASSES  = nn_pkg::N_CLASSES,
    parameter int SCORE_W    = nn_pkg::SCORE_W,
    parameter int IDX_W      = nn_pkg::IDX_W,
    parameter int CNT_W      = 16,
    parameter int SIGNED_CMP = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SCORE_W-1:0] scores [N_CLASSES],
    input  logic [IDX_W-1:0]   label,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [IDX_W-1:0]   class_idx,
    output logic [SCORE_W-1:0] max_score,
    output logic               correct,
    input  logic               clear_stats,
    output logic [CNT_W-1:0]   correct_count,
    output logic [CNT_W-1:0]   total_count
);

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // in_ready is high only in IDLE; out_valid is high only in DONE and the
    // result stays stable until out_ready completes the transfer.
    nn_pkg::argmax_state_e state, state_nxt;

    logic [SCORE_W-1:0] reg_scores [N_CLASSES];
    logic [IDX_W-1:0]   reg_label;
    logic [IDX_W-1:0]   best_idx;
    logic [SCORE_W-1:0] best;
    logic [IDX_W-1:0]   i;

    logic               gt;
    logic               last;
    logic               accept;
    logic               deliver;
    logic               label_ok;
    logic [IDX_W-1:0]   nxt_idx;
    logic [SCORE_W-1:0] nxt_best;

    score_compare #(
        .W          (SCORE_W),
        .SIGNED_CMP (SIGNED_CMP)
    ) u_cmp (
        .a  (reg_scores[i]),
        .b  (best),
        .gt (gt)
    );

    assign in_ready  = rst_n && (state == nn_pkg::IDLE);
    assign out_valid = (state == nn_pkg::DONE);
    assign accept    = (state == nn_pkg::IDLE) && in_valid;
    assign deliver   = (state == nn_pkg::DONE) && out_ready;
    assign last      = (i == IDX_W'(N_CLASSES - 1));
    assign nxt_idx   = gt ? i : best_idx;
    assign nxt_best  = gt ? reg_scores[i] : best;
    // Out-of-range labels can never match a real class index.
    assign label_ok  = 32'(reg_label) < N_CLASSES;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= nn_pkg::IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            nn_pkg::IDLE: if (in_valid) state_nxt = (N_CLASSES == 1) ? nn_pkg::DONE : nn_pkg::SCAN;
            nn_pkg::SCAN: if (last)     state_nxt = nn_pkg::DONE;
            nn_pkg::DONE: if (out_ready) state_nxt = nn_pkg::IDLE;
            default:                    state_nxt = nn_pkg::IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_CLASSES; k++) reg_scores[k] <= '0;
            reg_label <= '0;
            best_idx  <= '0;
            best      <= '0;
            i         <= '0;
            class_idx <= '0;
            max_score <= '0;
            correct   <= 1'b0;
        end else if (accept) begin
            for (int k = 0; k < N_CLASSES; k++) reg_scores[k] <= scores[k];
            reg_label <= label;
            best_idx  <= '0;
            best      <= scores[0];
            i         <= IDX_W'(1);
            if (N_CLASSES == 1) begin
                class_idx <= '0;
                max_score <= scores[0];
                correct   <= (label == '0);
            end
        end else if (state == nn_pkg::SCAN) begin
            best     <= nxt_best;
            best_idx <= nxt_idx;
            i        <= i + IDX_W'(1);
            // Publish the result on the same edge as the final compare.
            if (last) begin
                class_idx <= nxt_idx;
                max_score <= nxt_best;
                correct   <= (nxt_idx == reg_label) && label_ok;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            correct_count <= '0;
            total_count   <= '0;
        end else if (clear_stats) begin
            correct_count <= '0;
            total_count   <= '0;
        end else if (deliver) begin
            if (total_count != '1)            total_count   <= total_count + CNT_W'(1);
            if (correct && correct_count != '1) correct_count <= correct_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_argmax_scorer.sv
// Bench for argmax_scorer: a signed 16-bit-counter instance and an unsigned
// 2-bit-counter instance share stimulus and are checked against a loop model.
`timescale 1ns/1ps
module tb_argmax_scorer;

  localparam int N  = 10;
  localparam int W  = 64;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic clear_stats = 1'b0;
  logic [W-1:0] scores [N];
  logic [IW-1:0] label = '0;

  logic in_ready, out_valid, correct;
  logic [IW-1:0] class_idx;
  logic [W-1:0] max_score;
  logic [15:0] correct_count, total_count;

  logic in_ready_u, out_valid_u, correct_u;
  logic [IW-1:0] class_idx_u;
  logic [W-1:0] max_score_u;
  logic [1:0] correct_count_u, total_count_u;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_cc = 0, exp_tc = 0, exp_cc_u = 0, exp_tc_u = 0;

  always #5 clk = ~clk;

  argmax_scorer #(.N_CLASSES(N), .SCORE_W(W), .IDX_W(IW), .CNT_W(16), .SIGNED_CMP(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .scores(scores), .label(label), .out_valid(out_valid), .out_ready(out_ready),
    .class_idx(class_idx), .max_score(max_score), .correct(correct),
    .clear_stats(clear_stats), .correct_count(correct_count), .total_count(total_count)
  );

  argmax_scorer #(.N_CLASSES(N), .SCORE_W(W), .IDX_W(IW), .CNT_W(2), .SIGNED_CMP(0)) dut_u (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_u),
    .scores(scores), .label(label), .out_valid(out_valid_u), .out_ready(out_ready),
    .class_idx(class_idx_u), .max_score(max_score_u), .correct(correct_u),
    .clear_stats(clear_stats), .correct_count(correct_count_u), .total_count(total_count_u)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: lowest index holding the maximum under the chosen ordering.
  function automatic void ref_argmax(input bit sgn, output logic [IW-1:0] idx, output logic [W-1:0] best);
    int k = 0;
    for (int j = 1; j < N; j++) begin
      if (sgn ? ($signed(scores[j]) > $signed(scores[k])) : (scores[j] > scores[k])) k = j;
    end
    idx = IW'(k);
    best = scores[k];
  endfunction

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  // Drives one vector, holds the result for 'hold' cycles, then hands it off.
  task automatic run_vector(input int hold, input bit clr);
    logic [IW-1:0] e_idx, e_idx_u, lbl;
    logic [W-1:0] e_best, e_best_u;
    bit e_cor, e_cor_u;
    int lat, guard;
    ref_argmax(1'b1, e_idx, e_best);
    ref_argmax(1'b0, e_idx_u, e_best_u);
    lbl = label;
    e_cor = (e_idx == lbl);
    e_cor_u = (e_idx_u == lbl);
    guard = 0;
    while (!in_ready && guard < 50) begin step(); guard++; end
    n_cmp++;
    if (in_ready !== 1'b1 || in_ready_u !== 1'b1) begin
      n_bad++; $display("FAIL in_ready_wait: got %b/%b want 1/1", in_ready, in_ready_u);
    end
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int j = 0; j < N; j++) scores[j] = {$urandom, $urandom};
    label = IW'($urandom_range(0, 15));
    lat = 0;
    while (!out_valid && lat < 50) begin
      n_cmp++;
      if (in_ready !== 1'b0) begin n_bad++; $display("FAIL scan_in_ready: got %b want 0", in_ready); end
      step(); lat++;
    end
    n_cmp++;
    if (lat !== N - 1 || out_valid_u !== 1'b1) begin
      n_bad++; $display("FAIL latency: got %0d (u valid %b) want %0d", lat, out_valid_u, N - 1);
    end
    n_cmp++;
    if (class_idx !== e_idx || max_score !== e_best || correct !== e_cor) begin
      n_bad++; $display("FAIL result_signed: got idx=%0d score=%h cor=%b want idx=%0d score=%h cor=%b",
                        class_idx, max_score, correct, e_idx, e_best, e_cor);
    end
    n_cmp++;
    if (class_idx_u !== e_idx_u || max_score_u !== e_best_u || correct_u !== e_cor_u) begin
      n_bad++; $display("FAIL result_unsigned: got idx=%0d score=%h cor=%b want idx=%0d score=%h cor=%b",
                        class_idx_u, max_score_u, correct_u, e_idx_u, e_best_u, e_cor_u);
    end
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      step();
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || class_idx !== e_idx || max_score !== e_best) begin
        n_bad++; $display("FAIL hold_stable: cyc %0d valid=%b ready=%b idx=%0d score=%h want 1/0/%0d/%h",
                          h, out_valid, in_ready, class_idx, max_score, e_idx, e_best);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    clear_stats = clr;
    step();
    out_ready = 1'b0;
    clear_stats = 1'b0;
    if (clr) begin
      exp_cc = 0; exp_tc = 0; exp_cc_u = 0; exp_tc_u = 0;
    end else begin
      exp_tc = sat(exp_tc + 1, 65535);
      exp_cc = sat(exp_cc + int'(e_cor), 65535);
      exp_tc_u = sat(exp_tc_u + 1, 3);
      exp_cc_u = sat(exp_cc_u + int'(e_cor_u), 3);
    end
    n_cmp++;
    if (out_valid !== 1'b0 || out_valid_u !== 1'b0) begin
      n_bad++; $display("FAIL out_valid_drop: got %b/%b want 0/0", out_valid, out_valid_u);
    end
    n_cmp++;
    if (correct_count !== 16'(exp_cc) || total_count !== 16'(exp_tc)) begin
      n_bad++; $display("FAIL counts: got %0d/%0d want %0d/%0d", correct_count, total_count, exp_cc, exp_tc);
    end
    n_cmp++;
    if (correct_count_u !== 2'(exp_cc_u) || total_count_u !== 2'(exp_tc_u)) begin
      n_bad++; $display("FAIL counts_sat: got %0d/%0d want %0d/%0d", correct_count_u, total_count_u, exp_cc_u, exp_tc_u);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    n_cmp++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || class_idx !== '0 || max_score !== '0 ||
        correct !== 1'b0 || correct_count !== '0 || total_count !== '0) begin
      n_bad++; $display("FAIL reset_state: rdy=%b vld=%b idx=%0d score=%h cor=%b cc=%0d tc=%0d want all 0",
                        in_ready, out_valid, class_idx, max_score, correct, correct_count, total_count);
    end
    rst_n = 1'b1;
    step();
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL idle_after_reset: rdy=%b vld=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_distinct();
    for (int j = 0; j < N; j++) scores[j] = W'(j);
    scores[7] = 64'd70;
    label = 4'd7;
    run_vector(0, 1'b0);
  endtask

  task automatic test_tie_signed();
    for (int j = 0; j < N; j++) scores[j] = -64'sd5;
    scores[3] = -64'sd1;
    scores[6] = -64'sd1;
    label = 4'd3;
    run_vector(0, 1'b0);
  endtask

  task automatic test_backpressure();
    for (int j = 0; j < N; j++) scores[j] = {$urandom, $urandom};
    label = IW'($urandom_range(0, 9));
    run_vector(20, 1'b0);
  endtask

  task automatic test_mismatch();
    for (int j = 0; j < N; j++) scores[j] = W'($urandom_range(0, 50));
    scores[2] = 64'd1000;
    label = 4'd4;
    run_vector(0, 1'b0);
    for (int j = 0; j < N; j++) scores[j] = W'($urandom_range(0, 50));
    scores[9] = 64'd1000;
    label = 4'd12;
    run_vector(2, 1'b0);
  endtask

  task automatic test_clear();
    logic [IW-1:0] w;
    logic [W-1:0] b;
    for (int v = 0; v < 4; v++) begin
      for (int j = 0; j < N; j++) scores[j] = {$urandom, $urandom};
      label = IW'($urandom_range(0, 9));
      run_vector(0, v == 3);
    end
    clear_stats = 1'b1;
    step();
    clear_stats = 1'b0;
    exp_cc = 0; exp_tc = 0; exp_cc_u = 0; exp_tc_u = 0;
    n_cmp++;
    if (correct_count !== '0 || total_count !== '0 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL clear_idle: got cc=%0d tc=%0d rdy=%b want 0/0/1", correct_count, total_count, in_ready);
    end
    // Non-negative scores make both orderings agree, so every vector is correct.
    for (int v = 0; v < 5; v++) begin
      for (int j = 0; j < N; j++) scores[j] = W'($urandom_range(0, 1000));
      ref_argmax(1'b1, w, b);
      label = w;
      run_vector(0, 1'b0);
    end
  endtask

  task automatic test_reset_mid_scan();
    for (int j = 0; j < N; j++) scores[j] = {$urandom, $urandom};
    label = 4'd1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    exp_cc = 0; exp_tc = 0; exp_cc_u = 0; exp_tc_u = 0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || correct_count !== '0 || total_count !== '0 ||
        total_count_u !== '0) begin
      n_bad++; $display("FAIL reset_mid_scan: vld=%b rdy=%b cc=%0d tc=%0d tcu=%0d want 0",
                        out_valid, in_ready, correct_count, total_count, total_count_u);
    end
    step();
    rst_n = 1'b1;
    step();
    for (int j = 0; j < N; j++) scores[j] = {$urandom, $urandom};
    label = IW'($urandom_range(0, 9));
    run_vector(1, 1'b0);
  endtask

  task automatic test_random();
    logic [IW-1:0] w;
    logic [W-1:0] b;
    for (int v = 0; v < 16; v++) begin
      for (int j = 0; j < N; j++) begin
        if (v[0]) scores[j] = W'($signed($urandom_range(0, 6)) - 3);
        else      scores[j] = {$urandom, $urandom};
      end
      ref_argmax(1'b1, w, b);
      label = ($urandom_range(0, 1) == 1) ? w : IW'($urandom_range(0, 15));
      run_vector($urandom_range(0, 3), 1'b0);
    end
  endtask

  initial begin
    for (int j = 0; j < N; j++) scores[j] = '0;
    test_reset();
    test_distinct();
    test_tie_signed();
    test_backpressure();
    test_mismatch();
    test_clear();
    test_reset_mid_scan();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
